// File: rtl/pll_seq_ctrl_if.sv
// Control-pin bundle between pll_seq_ctrl (master) and the avsdpll_1v8 macro / SoC clock mux side (slave).
interface pll_seq_ctrl_if;
  logic       pll_req;
  logic [3:0] cfg_b;
  logic [7:0] exp_cnt;
  logic       fb_tgl;
  logic       enb_cp;
  logic       enb_vco;
  logic [3:0] b;
  logic       clk_sel;
  logic       locked;
  logic       fault;
  logic [2:0] state;

  modport master (
    input  pll_req, cfg_b, exp_cnt, fb_tgl,
    output enb_cp, enb_vco, b, clk_sel, locked, fault, state
  );

  modport slave (
    output pll_req, cfg_b, exp_cnt, fb_tgl,
    input  enb_cp, enb_vco, b, clk_sel, locked, fault, state
  );
endinterface

// File: rtl/pll_seq_ctrl.sv
// Power-up and lock sequencer for the avsdpll_1v8 PLL: enables, divider latch, lock qualification, clock select.
// Optional build macro PLL_CTRL_MONITOR_EN keeps measuring while LOCKED and falls back to SETTLE on loss of lock.
module pll_seq_ctrl #(
  parameter int SETTLE_CYCLES = 1024,
  parameter int WIN_CYCLES    = 256,
  parameter int TOL           = 2,
  parameter int MAX_RETRY     = 3
) (
  input  logic           ref_clk,
  input  logic           porb,
  pll_seq_ctrl_if.master pll
);
  localparam int CP_CYCLES = 16;
  localparam int CYC_SW    = (SETTLE_CYCLES > WIN_CYCLES) ? SETTLE_CYCLES : WIN_CYCLES;
  localparam int CYC_MAX   = (CYC_SW > CP_CYCLES) ? CYC_SW : CP_CYCLES;
  localparam int CW        = $clog2(CYC_MAX);
  localparam int RW        = $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {
    OFF     = 3'd0,
    CP_ON   = 3'd1,
    VCO_ON  = 3'd2,
    SETTLE  = 3'd3,
    MEASURE = 3'd4,
    LOCKED  = 3'd5,
    FAULT   = 3'd6
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cyc, cyc_nxt;
  logic [7:0]    edge_cnt, edge_nxt, cnt_upd;
  logic [RW-1:0] retry, retry_nxt;
  logic [3:0]    b_q, b_nxt;
  logic          win_end, in_tol;
  logic          fb_s1_p0, fb_s2_p1, fb_s3_p2, fb_rise;
  logic          enb_cp_q, enb_vco_q, clk_sel_q, locked_q, fault_q;

  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic inc);
    if (inc && (v != 8'hFF)) return v + 8'd1;
    return v;
  endfunction

  function automatic logic within_tol(input logic [7:0] cnt, input logic [7:0] exp_v);
    logic signed [8:0] d;
    d = $signed({1'b0, cnt}) - $signed({1'b0, exp_v});
    if (d[8]) d = -d;
    return (d <= $signed(9'(TOL)));
  endfunction

  // Stage p0/p1: two-flop synchronizer for the clk_pll-domain toggle; p2: edge-detect history
  always_ff @(posedge ref_clk or negedge porb) begin
    if (!porb) begin
      fb_s1_p0 <= 1'b0;
      fb_s2_p1 <= 1'b0;
      fb_s3_p2 <= 1'b0;
    end else begin
      fb_s1_p0 <= pll.fb_tgl;
      fb_s2_p1 <= fb_s1_p0;
      fb_s3_p2 <= fb_s2_p1;
    end
  end

  assign fb_rise = fb_s2_p1 & ~fb_s3_p2;

  always_ff @(posedge ref_clk or negedge porb) begin
    if (!porb) state <= OFF;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cyc_nxt   = '0;
    edge_nxt  = edge_cnt;
    retry_nxt = retry;
    b_nxt     = b_q;
    cnt_upd   = sat_inc(edge_cnt, fb_rise);
    win_end   = (cyc == CW'(WIN_CYCLES - 1));
    // The edge seen in the final window cycle is folded in before judging the window
    in_tol    = within_tol(cnt_upd, pll.exp_cnt);
    case (state)
      OFF: begin
        if (pll.pll_req) begin
          state_nxt = CP_ON;
          b_nxt     = pll.cfg_b;
          retry_nxt = '0;
        end
      end
      CP_ON: begin
        if (cyc == CW'(CP_CYCLES - 1)) state_nxt = VCO_ON;
        else                           cyc_nxt   = cyc + CW'(1);
      end
      VCO_ON: state_nxt = SETTLE;
      SETTLE: begin
        if (cyc == CW'(SETTLE_CYCLES - 1)) begin
          state_nxt = MEASURE;
          edge_nxt  = '0;
        end else begin
          cyc_nxt = cyc + CW'(1);
        end
      end
      MEASURE: begin
        if (win_end) begin
          edge_nxt = '0;
          if (in_tol) begin
            state_nxt = LOCKED;
          end else begin
            retry_nxt = retry + RW'(1);
            state_nxt = (retry_nxt == RW'(MAX_RETRY)) ? FAULT : SETTLE;
          end
        end else begin
          edge_nxt = cnt_upd;
          cyc_nxt  = cyc + CW'(1);
        end
      end
      LOCKED: begin
`ifdef PLL_CTRL_MONITOR_EN
        if (win_end) begin
          edge_nxt = '0;
          if (!in_tol) begin
            state_nxt = SETTLE;
            retry_nxt = '0;
          end
        end else begin
          edge_nxt = cnt_upd;
          cyc_nxt  = cyc + CW'(1);
        end
`else
        cyc_nxt = cyc;
`endif
      end
      FAULT: ;
      default: state_nxt = OFF;
    endcase
    // Dropping the request is a one-cycle shutdown from anywhere
    if (!pll.pll_req) state_nxt = OFF;
  end

  always_ff @(posedge ref_clk or negedge porb) begin
    if (!porb) begin
      cyc      <= '0;
      edge_cnt <= '0;
      retry    <= '0;
      b_q      <= '0;
    end else begin
      cyc      <= cyc_nxt;
      edge_cnt <= edge_nxt;
      retry    <= retry_nxt;
      b_q      <= b_nxt;
    end
  end

  // Outputs are registered from the next state so they line up with the state register
  always_ff @(posedge ref_clk or negedge porb) begin
    if (!porb) begin
      enb_cp_q  <= 1'b1;
      enb_vco_q <= 1'b1;
      clk_sel_q <= 1'b0;
      locked_q  <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      enb_cp_q  <= !(state_nxt inside {CP_ON, VCO_ON, SETTLE, MEASURE, LOCKED});
      enb_vco_q <= !(state_nxt inside {VCO_ON, SETTLE, MEASURE, LOCKED});
      clk_sel_q <= (state_nxt == LOCKED);
      locked_q  <= (state_nxt == LOCKED);
      fault_q   <= (state_nxt == FAULT);
    end
  end

  assign pll.enb_cp  = enb_cp_q;
  assign pll.enb_vco = enb_vco_q;
  assign pll.b       = b_q;
  assign pll.clk_sel = clk_sel_q;
  assign pll.locked  = locked_q;
  assign pll.fault   = fault_q;
  assign pll.state   = state;
endmodule

// File: tb/tb_pll_seq_ctrl.sv
// Self-checking bench for pll_seq_ctrl: timeline-based reference model plus directed literal checks.
module tb_pll_seq_ctrl;
  localparam int S    = 64;
  localparam int W    = 32;
  localparam int TOLV = 2;
  localparam int MR   = 3;
  localparam int WS   = 1024;

  logic ref_clk = 1'b0;
  logic porb    = 1'b1;
  logic fb      = 1'b0;
  bit   fb_run  = 1'b0;
  int   ph      = 0;
  int   n_asrt  = 0;
  int   n_fail  = 0;
  int   rel     = 0;

  always #5 ref_clk = ~ref_clk;

  pll_seq_ctrl_if m_if();
  pll_seq_ctrl_if s_if();

  assign m_if.fb_tgl = fb;
  assign s_if.fb_tgl = fb;

  pll_seq_ctrl #(.SETTLE_CYCLES(S), .WIN_CYCLES(W), .TOL(TOLV), .MAX_RETRY(MR)) dut (
    .ref_clk (ref_clk),
    .porb    (porb),
    .pll     (m_if)
  );

  pll_seq_ctrl #(.SETTLE_CYCLES(S), .WIN_CYCLES(WS), .TOL(TOLV), .MAX_RETRY(MR)) dut_sat (
    .ref_clk (ref_clk),
    .porb    (porb),
    .pll     (s_if)
  );

  task automatic chk(input string name, input int act, input int req);
    n_asrt++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Advance to relative edge t, then settle 1 time unit past it
  task automatic to(input int t);
    repeat (t - rel) @(posedge ref_clk);
    #1;
    rel = t;
  endtask

  // fb_tgl generator: toggles every 2 cycles (period 4) while running, else held low
  initial forever begin
    @(posedge ref_clk);
    #3;
    if (fb_run) begin
      ph++;
      if (ph == 2) begin
        fb = ~fb;
        ph = 0;
      end
    end else begin
      fb = 1'b0;
    end
  end

  // Reference model: absolute deadlines per phase, window counts from recorded fb samples
  int   n       = 0;
  int   ms      = 0;
  int   dl      = 0;
  int   m0      = 0;
  int   retry_m = 0;
  logic [3:0] b_m = 4'd0;
  logic fb_hist [0:16383];

  function automatic int win_count(input int start);
    int c;
    c = 0;
    for (int m = start; m < start + W; m++)
      if (fb_hist[m-1] === 1'b1 && fb_hist[m-2] === 1'b0) c++;
    return (c > 255) ? 255 : c;
  endfunction

  function automatic bit in_tol(input int c, input int e);
    return ((c - e) <= TOLV) && ((e - c) <= TOLV);
  endfunction

  always @(posedge ref_clk or negedge porb) begin
    if (!porb) begin
      ms      = 0;
      b_m     = 4'd0;
      retry_m = 0;
    end else begin
      fb_hist[n] = fb;
      if (!m_if.pll_req) begin
        ms = 0;
      end else begin
        case (ms)
          0: begin ms = 1; b_m = m_if.cfg_b; retry_m = 0; dl = n + 16; end
          1: if (n == dl) ms = 2;
          2: begin ms = 3; dl = n + S; end
          3: if (n == dl) begin ms = 4; m0 = n; dl = n + W; end
          4: if (n == dl) begin
               if (in_tol(win_count(m0), int'(m_if.exp_cnt))) begin
                 ms = 5; m0 = n; dl = n + W;
               end else begin
                 retry_m++;
                 if (retry_m == MR) ms = 6;
                 else begin ms = 3; dl = n + S; end
               end
             end
          5: begin
`ifdef PLL_CTRL_MONITOR_EN
               if (n == dl) begin
                 if (in_tol(win_count(m0), int'(m_if.exp_cnt))) begin
                   m0 = n; dl = n + W;
                 end else begin
                   ms = 3; dl = n + S; retry_m = 0;
                 end
               end
`endif
             end
          default: ;
        endcase
      end
      n++;
    end
  end

  always @(negedge ref_clk) begin
    chk("m_state",   int'(m_if.state),   ms);
    chk("m_enb_cp",  int'(m_if.enb_cp),  int'(!(ms >= 1 && ms <= 5)));
    chk("m_enb_vco", int'(m_if.enb_vco), int'(!(ms >= 2 && ms <= 5)));
    chk("m_clk_sel", int'(m_if.clk_sel), int'(ms == 5));
    chk("m_locked",  int'(m_if.locked),  int'(ms == 5));
    chk("m_fault",   int'(m_if.fault),   int'(ms == 6));
    chk("m_b",       int'(m_if.b),       int'(b_m));
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin
    m_if.pll_req = 1'b0;
    m_if.cfg_b   = 4'b1010;
    m_if.exp_cnt = 8'd8;
    s_if.pll_req = 1'b0;
    s_if.cfg_b   = 4'b0011;
    s_if.exp_cnt = 8'd255;
    #1 porb = 1'b0;
    repeat (3) @(posedge ref_clk);
    #1;
    chk("rst_state",   int'(m_if.state),   0);
    chk("rst_enb_cp",  int'(m_if.enb_cp),  1);
    chk("rst_enb_vco", int'(m_if.enb_vco), 1);
    chk("rst_b",       int'(m_if.b),       0);
    chk("rst_clk_sel", int'(m_if.clk_sel), 0);
    chk("rst_fault",   int'(m_if.fault),   0);
    porb   = 1'b1;
    fb_run = 1'b1;
    repeat (4) @(posedge ref_clk);
    #1;
    chk("idle_off", int'(m_if.state), 0);

    // Nominal lock, exp_cnt=8, 8 edges per window
    rel = 0; m_if.pll_req = 1'b1;
    to(1);   chk("nom_enb_cp_e1", int'(m_if.enb_cp), 0); chk("nom_state_e1", int'(m_if.state), 1);
    to(16);  chk("nom_enb_vco_e16", int'(m_if.enb_vco), 1);
    to(17);  chk("nom_enb_vco_e17", int'(m_if.enb_vco), 0); chk("nom_b", int'(m_if.b), 10);
    to(18);  chk("nom_settle_e18", int'(m_if.state), 3);
    to(113); chk("nom_locked_e113", int'(m_if.locked), 0);
    to(114); chk("nom_locked_e114", int'(m_if.locked), 1); chk("nom_clk_sel_e114", int'(m_if.clk_sel), 1);
    m_if.pll_req = 1'b0;
    to(115); chk("drop_state", int'(m_if.state), 0); chk("drop_clk_sel", int'(m_if.clk_sel), 0);
    chk("drop_enb_cp", int'(m_if.enb_cp), 1); chk("drop_enb_vco", int'(m_if.enb_vco), 1);

    // Tolerance edge: measured 8 vs exp 10 locks
    to(117); rel = 0; m_if.exp_cnt = 8'd10; m_if.pll_req = 1'b1;
    to(114); chk("tol10_locked", int'(m_if.locked), 1);
    m_if.pll_req = 1'b0;
    to(116); rel = 0; m_if.exp_cnt = 8'd11; m_if.pll_req = 1'b1;
    // Measured 8 vs exp 11 retries
    to(114); chk("tol11_retry_state", int'(m_if.state), 3); chk("tol11_locked", int'(m_if.locked), 0);
    to(190); chk("abort_in_measure", int'(m_if.state), 4);
    m_if.pll_req = 1'b0; m_if.cfg_b = 4'b0101;
    to(191); chk("abort_state", int'(m_if.state), 0); chk("abort_enb_cp", int'(m_if.enb_cp), 1);
    chk("abort_enb_vco", int'(m_if.enb_vco), 1); chk("abort_clk_sel", int'(m_if.clk_sel), 0);
    to(193); rel = 0; m_if.exp_cnt = 8'd8; m_if.pll_req = 1'b1;
    to(1);   chk("relatch_b", int'(m_if.b), 5);
    to(114); chk("relatch_locked", int'(m_if.locked), 1);

    // Async reset while LOCKED, checked before any clock edge
    to(120); porb = 1'b0;
    #1;
    chk("areset_state", int'(m_if.state), 0); chk("areset_enb_cp", int'(m_if.enb_cp), 1);
    chk("areset_locked", int'(m_if.locked), 0); chk("areset_b", int'(m_if.b), 0);
    m_if.pll_req = 1'b0;
    to(123); porb = 1'b1;
    to(128); chk("post_reset_off", int'(m_if.state), 0); chk("post_reset_enb_cp", int'(m_if.enb_cp), 1);

    // Lock, then stop fb_tgl
    rel = 0; m_if.pll_req = 1'b1;
    to(114); chk("mon_locked", int'(m_if.locked), 1);
    fb_run = 1'b0;
    to(194);
`ifdef PLL_CTRL_MONITOR_EN
    chk("mon_lost_state", int'(m_if.state), 3); chk("mon_lost_locked", int'(m_if.locked), 0);
`else
    chk("mon_hold_state", int'(m_if.state), 5); chk("mon_hold_locked", int'(m_if.locked), 1);
`endif

    // fb stuck low: three failed windows end in FAULT at edge 306
    m_if.pll_req = 1'b0;
    to(196); rel = 0; m_if.pll_req = 1'b1;
    to(114); chk("stuck_retry1", int'(m_if.state), 3);
    to(305); chk("stuck_measure3", int'(m_if.state), 4);
    to(306); chk("stuck_fault_state", int'(m_if.state), 6); chk("stuck_fault", int'(m_if.fault), 1);
    chk("stuck_enb_cp", int'(m_if.enb_cp), 1); chk("stuck_enb_vco", int'(m_if.enb_vco), 1);
    m_if.pll_req = 1'b0;
    to(307); chk("fault_clear_state", int'(m_if.state), 0); chk("fault_clear", int'(m_if.fault), 0);

    // Saturation: 256 edges in a 1024-cycle window clamp to 255 and match exp_cnt=255
    fb_run = 1'b1;
    to(310); rel = 0; s_if.pll_req = 1'b1;
    to(1105); chk("sat_not_yet", int'(s_if.locked), 0); chk("sat_measure", int'(s_if.state), 4);
    to(1106); chk("sat_locked", int'(s_if.locked), 1); chk("sat_clk_sel", int'(s_if.clk_sel), 1);
    s_if.pll_req = 1'b0;
    to(1108);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
